lzw_dec_ctrl: RTL and testbench

- LZW decompression controller; the decode-side counterpart of the compression controller.
- Accepts CODE_W-bit codes over a valid/ready stream and rebuilds each string by walking the prefix/append-char dictionary RAMs.
- Reverses each chain in an internal LIFO, emits bytes over a valid/ready stream, and writes one new dictionary entry per code.
- Sits between the code input buffer and the output byte register. Kicked off by top_ctrl with init_lzd.

---
 rtl/lzw_dec_if.sv | 38 +++
 rtl/lzw_dec_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lzw_dec_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzw_dec_if.sv
// rtl/lzw_dec_if.sv - code stream, dictionary and byte stream bundle for the LZW decoder
interface lzw_dec_if #(
  parameter int CODE_W = 13
);
  logic              init_lzd;
  logic [CODE_W-1:0] code_in;
  logic              code_vld;
  logic              code_last;
  logic              code_rdy;
  logic              dict_en;
  logic [CODE_W-1:0] dict_addr;
  logic [CODE_W-1:0] prefix_rd;
  logic [7:0]        char_rd;
  logic              dict_we;
  logic [CODE_W-1:0] dict_waddr;
  logic [CODE_W-1:0] dict_wprefix;
  logic [7:0]        dict_wchar;
  logic [7:0]        out_byte;
  logic              out_vld;
  logic              out_last;
  logic              out_rdy;
  logic              lzd_done;
  logic              err;

  // decoder side
  modport slave (
    input  init_lzd, code_in, code_vld, code_last, prefix_rd, char_rd, out_rdy,
    output code_rdy, dict_en, dict_addr, dict_we, dict_waddr, dict_wprefix, dict_wchar,
           out_byte, out_vld, out_last, lzd_done, err
  );

  // environment side: code source, dictionary RAMs, byte sink, top_ctrl
  modport master (
    output init_lzd, code_in, code_vld, code_last, prefix_rd, char_rd, out_rdy,
    input  code_rdy, dict_en, dict_addr, dict_we, dict_waddr, dict_wprefix, dict_wchar,
           out_byte, out_vld, out_last, lzd_done, err
  );
endinterface

// File: rtl/lzw_dec_ctrl.sv
// rtl/lzw_dec_ctrl.sv - LZW decode controller: dictionary walk, LIFO reversal, byte output
module lzw_dec_ctrl #(
  parameter int CODE_W      = 13,
  parameter int STACK_DEPTH = 8192
) (
  input  logic     clk,
  input  logic     rst_n,
  lzw_dec_if.slave bus
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int AW   = $clog2(STACK_DEPTH);
  localparam logic [CODE_W:0] MAX_CODE   = {1'b0, {CODE_W{1'b1}}};
  localparam logic [CODE_W:0] FIRST_DICT = (CODE_W + 1)'(256);
  localparam logic [SP_W-1:0] SP_FULL    = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);

  typedef enum logic [7:0] {
    DIDLE    = 8'b0000_0001,
    DWT_CODE = 8'b0000_0010,
    DWALK    = 8'b0000_0100,
    DWT_DICT = 8'b0000_1000,
    DPOP     = 8'b0001_0000,
    DUPD     = 8'b0010_0000,
    DDONE    = 8'b0100_0000,
    DERR     = 8'b1000_0000
  } state_t;

  state_t            r_state, w_next;
  logic [CODE_W:0]   r_next_code;
  logic [CODE_W-1:0] r_prev_code;
  logic [CODE_W-1:0] r_cur;
  logic [CODE_W-1:0] r_walk;
  logic [7:0]        r_fc;
  logic [SP_W-1:0]   r_sp;
  logic              r_first;
  logic              r_last;
  logic              r_done;
  logic [7:0]        r_stack [STACK_DEPTH];

  logic [CODE_W:0]   w_code_ext;
  logic              w_code_bad;
  logic              w_kwk;
  logic              w_walk_lit;
  logic              w_dict_open;
  logic              w_push;
  logic [7:0]        w_push_data;
  logic              w_overflow;
  logic              w_out_vld;
  logic              w_dict_en;
  logic              w_dict_we;

  assign w_code_ext  = {1'b0, bus.code_in};
  // a code may only reference what already exists, or the one entry about to be made
  assign w_code_bad  = (w_code_ext > r_next_code)
                     || (r_first && (|bus.code_in[CODE_W-1:8]))
                     || ((w_code_ext == MAX_CODE) && (r_next_code <= MAX_CODE));
  assign w_kwk       = (w_code_ext == r_next_code);
  assign w_walk_lit  = ~(|r_walk[CODE_W-1:8]);
  assign w_dict_open = !r_first && (r_next_code <= MAX_CODE);
  assign w_overflow  = w_push && (r_sp == SP_FULL);

  // select what (if anything) goes onto the reversal LIFO this cycle
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 8'd0;
    unique case (r_state)
      DWT_CODE: begin
        if (bus.code_vld && !w_code_bad && w_kwk) begin
          w_push      = 1'b1;
          w_push_data = r_fc;
        end
      end
      DWALK: begin
        if (w_walk_lit) begin
          w_push      = 1'b1;
          w_push_data = r_walk[7:0];
        end
      end
      DWT_DICT: begin
        w_push      = 1'b1;
        w_push_data = bus.char_rd;
      end
      default: ;
    endcase
  end

  // next-state decode; a LIFO overflow overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DIDLE:    if (bus.init_lzd) w_next = DWT_CODE;
      DWT_CODE: if (bus.code_vld) w_next = w_code_bad ? DERR : DWALK;
      DWALK:    w_next = w_walk_lit ? DPOP : DWT_DICT;
      DWT_DICT: w_next = DWALK;
      DPOP:     if (bus.out_rdy && (r_sp == SP_ONE)) w_next = DUPD;
      DUPD:     w_next = r_last ? DDONE : DWT_CODE;
      DDONE:    w_next = DIDLE;
      DERR:     if (bus.init_lzd) w_next = DWT_CODE;
      default:  w_next = DIDLE;
    endcase
    if (w_overflow) w_next = DERR;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DIDLE;
      r_next_code <= FIRST_DICT;
      r_prev_code <= '0;
      r_cur       <= '0;
      r_walk      <= '0;
      r_fc        <= 8'd0;
      r_sp        <= '0;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == DDONE);
      if (w_push && !w_overflow) r_sp <= r_sp + SP_ONE;
      unique case (r_state)
        DIDLE, DERR: begin
          if (bus.init_lzd) begin
            r_next_code <= FIRST_DICT;
            r_first     <= 1'b1;
            r_sp        <= '0;
          end
        end
        DWT_CODE: begin
          if (bus.code_vld) begin
            r_cur  <= bus.code_in;
            r_last <= bus.code_last;
            r_walk <= w_kwk ? r_prev_code : bus.code_in;
          end
        end
        DWALK:    if (w_walk_lit) r_fc <= r_walk[7:0];
        DWT_DICT: r_walk <= bus.prefix_rd;
        DPOP:     if (bus.out_rdy) r_sp <= r_sp - SP_ONE;
        DUPD: begin
          if (w_dict_open) r_next_code <= r_next_code + (CODE_W + 1)'(1);
          r_prev_code <= r_cur;
          r_first     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // LIFO storage; contents need no reset since sp bounds what is visible
  always_ff @(posedge clk) begin
    if (w_push && !w_overflow) r_stack[AW'(r_sp)] <= w_push_data;
  end

  assign w_out_vld = (r_state == DPOP);
  assign w_dict_en = (r_state == DWALK) && !w_walk_lit;
  assign w_dict_we = (r_state == DUPD) && w_dict_open;

  assign bus.code_rdy     = (r_state == DWT_CODE);
  assign bus.dict_en      = w_dict_en;
  assign bus.dict_addr    = w_dict_en ? r_walk : '0;
  assign bus.dict_we      = w_dict_we;
  assign bus.dict_waddr   = w_dict_we ? r_next_code[CODE_W-1:0] : '0;
  assign bus.dict_wprefix = w_dict_we ? r_prev_code : '0;
  assign bus.dict_wchar   = w_dict_we ? r_fc : 8'd0;
  assign bus.out_vld      = w_out_vld;
  assign bus.out_byte     = w_out_vld ? r_stack[AW'(r_sp - SP_ONE)] : 8'd0;
  assign bus.out_last     = w_out_vld && r_last && (r_sp == SP_ONE);
  assign bus.lzd_done     = r_done;
  assign bus.err          = (r_state == DERR);
endmodule

// File: tb/tb_lzw_dec_ctrl.sv
// tb/tb_lzw_dec_ctrl.sv - randomized self-checking bench for lzw_dec_ctrl
module tb_lzw_dec_ctrl;
  localparam int CW   = 9;
  localparam int SD   = 512;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lzw_dec_if #(.CODE_W(CW)) bus ();
  lzw_dec_ctrl #(.CODE_W(CW), .STACK_DEPTH(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail(string name, int act, int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // dictionary RAMs with one cycle read latency
  logic [CW-1:0] ram_p [1 << CW];
  logic [7:0]    ram_c [1 << CW];
  always @(posedge clk) begin
    if (bus.dict_we) begin
      ram_p[bus.dict_waddr] <= bus.dict_wprefix;
      ram_c[bus.dict_waddr] <= bus.dict_wchar;
    end
    if (bus.dict_en) begin
      bus.prefix_rd <= ram_p[bus.dict_addr];
      bus.char_rd   <= ram_c[bus.dict_addr];
    end
  end

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_rdy = 1'($urandom_range(0, 1));
      1:       bus.out_rdy = 1'b1;
      2:       bus.out_rdy = 1'b0;
      default: bus.out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  end

  // behavioural model: every code maps to its full string
  typedef logic [7:0] bq_t[$];
  bq_t        m_str [1 << CW];
  int         m_next = 256;
  int         m_prev = 0;
  bit         m_first = 1'b1;
  logic [8:0] exp_b[$];
  int         exp_w[$];
  int         exp_lat[$];
  int         exp_done = 0;
  int         got_done = 0;
  logic [7:0] log_b[$];
  int         log_w[$];
  int         last_lat = -1;

  function automatic int wpack(int a, int p, int c);
    return (a << 20) | (p << 8) | c;
  endfunction

  function automatic bit model_code(int c, bit last);
    bq_t s;
    if (c > m_next || (m_first && c > 255) || (c == MAXC && m_next <= MAXC)) return 1'b0;
    if (c == m_next) begin
      s = m_str[m_prev];
      s.push_back(m_str[m_prev][0]);
      exp_lat.push_back(2 + 2 * (s.size() - 2));
    end else begin
      s = m_str[c];
      exp_lat.push_back(2 + 2 * (s.size() - 1));
    end
    foreach (s[i]) exp_b.push_back({last && (i == s.size() - 1), s[i]});
    if (!m_first && m_next <= MAXC) begin
      exp_w.push_back(wpack(m_next, m_prev, int'(s[0])));
      m_str[m_next] = m_str[m_prev];
      m_str[m_next].push_back(s[0]);
      m_next++;
    end
    m_prev = c;
    m_first = 1'b0;
    if (last) exp_done++;
    return 1'b1;
  endfunction

  function automatic int pick_code();
    int hi, c;
    if (m_first) return int'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    hi = (m_next > MAXC) ? MAXC : m_next;
    c = int'($urandom_range(256, hi));
    if (c == MAXC && m_next <= MAXC) c = m_next - 1;
    return c;
  endfunction

  // compare process
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'd0;
  int         hs_cyc = 0;
  int         want_lat = -1;
  always @(negedge clk) begin
    logic [8:0] e;
    int act;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_vld_held", int'(bus.out_vld), 1);
        chk("stall_byte_held", int'(bus.out_byte), int'(prev_byte));
      end
      if (bus.out_vld && want_lat >= 0) begin
        last_lat = cyc - hs_cyc;
        chk("first_byte_latency", last_lat, want_lat);
        want_lat = -1;
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_b.size() == 0) fail("unexpected_byte", int'(bus.out_byte), -1);
        else begin
          e = exp_b.pop_front();
          chk("out_byte", int'(bus.out_byte), int'(e[7:0]));
          chk("out_last", int'(bus.out_last), int'(e[8]));
          log_b.push_back(bus.out_byte);
        end
      end
      if (bus.dict_we) begin
        act = wpack(int'(bus.dict_waddr), int'(bus.dict_wprefix), int'(bus.dict_wchar));
        if (exp_w.size() == 0) fail("unexpected_dict_write", act, -1);
        else chk("dict_write", act, exp_w.pop_front());
        log_w.push_back(act);
      end
      if (bus.lzd_done) got_done++;
      if (bus.code_vld && bus.code_rdy) begin
        hs_cyc = cyc;
        if (exp_lat.size() > 0) want_lat = exp_lat.pop_front();
      end
      prev_stall = bus.out_vld && !bus.out_rdy;
      prev_byte = bus.out_byte;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic send(int c, bit last);
    int n = 0;
    void'(model_code(c, last));
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    bus.code_in = CW'(c);
    bus.code_vld = 1'b1;
    bus.code_last = last;
    while (!bus.code_rdy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) begin
      fail("code_rdy_timeout", c, -1);
      finish_now();
    end
    @(posedge clk);
    #1;
    bus.code_vld = 1'b0;
    bus.code_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_w.size() != 0 || got_done != exp_done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      fail("drain_timeout", exp_b.size(), 0);
      finish_now();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic do_init();
    m_next = 256;
    m_first = 1'b1;
    @(posedge clk);
    #1 bus.init_lzd = 1'b1;
    @(posedge clk);
    #1 bus.init_lzd = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_code_rdy"}, int'(bus.code_rdy), 0);
    chk({tag, "_dict_en"}, int'(bus.dict_en), 0);
    chk({tag, "_dict_addr"}, int'(bus.dict_addr), 0);
    chk({tag, "_dict_we"}, int'(bus.dict_we), 0);
    chk({tag, "_dict_waddr"}, int'(bus.dict_waddr), 0);
    chk({tag, "_out_vld"}, int'(bus.out_vld), 0);
    chk({tag, "_out_byte"}, int'(bus.out_byte), 0);
    chk({tag, "_out_last"}, int'(bus.out_last), 0);
    chk({tag, "_lzd_done"}, int'(bus.lzd_done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  task automatic chk_err(string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_err"}, int'(bus.err), 1);
    chk({tag, "_code_rdy"}, int'(bus.code_rdy), 0);
    chk({tag, "_out_vld"}, int'(bus.out_vld), 0);
  endtask

  // codes 65,66,256,258 decode to ABABABA with three new entries
  task automatic basic_stream(string tag);
    int d0;
    int wl [3];
    log_b.delete();
    log_w.delete();
    d0 = got_done;
    send(65, 0);
    send(66, 0);
    send(256, 0);
    send(258, 1);
    drain();
    wl[0] = (256 << 20) | (65 << 8) | 66;
    wl[1] = (257 << 20) | (66 << 8) | 65;
    wl[2] = (258 << 20) | (256 << 8) | 65;
    chk({tag, "_byte_count"}, log_b.size(), 7);
    for (int i = 0; i < 7 && i < log_b.size(); i++)
      chk({tag, "_byte_literal"}, int'(log_b[i]), (i % 2 == 0) ? 65 : 66);
    chk({tag, "_write_count"}, log_w.size(), 3);
    for (int i = 0; i < 3 && i < log_w.size(); i++)
      chk({tag, "_write_literal"}, log_w[i], wl[i]);
    chk({tag, "_done_pulses"}, got_done - d0, 1);
    chk({tag, "_model_next_code"}, m_next, 259);
  endtask

  initial begin
    #900000;
    fail("global_timeout", cyc, -1);
    finish_now();
  end

  initial begin
    int n, na, c;
    for (int i = 0; i < 256; i++) begin
      m_str[i].delete();
      m_str[i].push_back(8'(i));
    end
    bus.init_lzd = 1'b0;
    bus.code_in = '0;
    bus.code_vld = 1'b0;
    bus.code_last = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 1;
    do_init();
    basic_stream("basic");

    rdy_mode = 3;
    do_init();
    basic_stream("backpressure");

    rdy_mode = 1;
    do_init();
    send(65, 0);
    send(257, 0);
    drain();
    chk_err("code_above_next");
    do_init();
    chk("err_cleared", int'(bus.err), 0);
    send(256, 0);
    drain();
    chk_err("first_not_literal");
    do_init();
    send(65, 0);
    send(MAXC, 0);
    drain();
    chk_err("max_code_not_full");
    do_init();
    chk("err_cleared_again", int'(bus.err), 0);
    basic_stream("after_err");

    rdy_mode = 0;
    do_init();
    send(65, 0);
    for (int j = 0; j < 20; j++) send(256 + j, 0);
    drain();
    log_b.delete();
    send(275, 1);
    drain();
    chk("chain_latency", last_lat, 42);
    chk("chain_bytes", log_b.size(), 21);
    na = 0;
    foreach (log_b[i]) if (log_b[i] == 8'd65) na++;
    chk("chain_all_A", na, 21);

    do_init();
    log_w.delete();
    for (int i = 0; i < 258; i++) send(int'($urandom_range(0, 255)), 0);
    drain();
    chk("full_model_next_code", m_next, 512);
    chk("full_write_count", log_w.size(), 256);
    if (log_w.size() > 0) chk("full_last_waddr", log_w[log_w.size() - 1] >> 20, MAXC);
    log_w.delete();
    for (int i = 0; i < 40; i++) begin
      c = (i % 7 == 3) ? MAXC : pick_code();
      send(c, i == 39);
    end
    drain();
    chk("frozen_no_writes", log_w.size(), 0);

    for (int k = 0; k < 3; k++) begin
      do_init();
      n = int'($urandom_range(20, 30));
      for (int i = 0; i < n; i++) send(pick_code(), i == n - 1);
      drain();
    end

    rdy_mode = 1;
    do_init();
    send(65, 0);
    send(256, 0);
    drain();
    rdy_mode = 2;
    send(257, 0);
    n = 0;
    while (!bus.out_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midop_out_vld_seen", int'(bus.out_vld), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midop_reset");
    exp_b.delete();
    exp_w.delete();
    exp_lat.delete();
    want_lat = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    do_init();
    basic_stream("after_reset");

    chk("end_bytes_pending", exp_b.size(), 0);
    chk("end_done_count", got_done, exp_done);
    finish_now();
  end
endmodule
